hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 3-stage core (IF/ID, EX, WB). It pairs with the WB→EX forwarding path: it covers the hazards that path cannot resolve, namely load-use, taken-branch squash and multi-cycle data-memory waits. It drives the stall and flush enables of the pipeline registers and a sticky memory-timeout error. A small FSM tracks outstanding memory accesses.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_loaduse_cmp.sv | 23 ++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0          = 5'd0;
  localparam int         MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/hazard_loaduse_cmp.sv
// Combinational load-use comparator: the EX load's rd against the ID sources.
module hazard_loaduse_cmp
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       hit_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hit_o = ex_mem_read_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 3-stage core (load-use, branch squash, dmem waits).
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  output logic        stall_if_o,
  output logic        stall_id_o,
  output logic        stall_ex_o,
  output logic        bubble_ex_o,
  output logic        flush_id_o,
  output logic        mem_err_o,
  output logic [31:0] stall_cycles_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_hit;
  logic             hazard_eval;
  logic             stall_mem;
  logic             lu_stall;
  logic             bubble;
  logic             flush;

  hazard_loaduse_cmp u_cmp (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .ex_rd_i       (ex_rd_i),
    .ex_mem_read_i (ex_mem_read_i),
    .hit_o         (lu_hit)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hazard_eval = 1'b0;
    stall_mem   = 1'b0;
    lu_stall    = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;

    case (state_q)
      RUN: begin
        if (dmem_req_i && !dmem_ready_i) begin
          stall_mem = 1'b1;
          state_d   = MEM_WAIT;
          cnt_d     = CNT_W'(1);
        end else begin
          hazard_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_d     = RUN;
          cnt_d       = '0;
          hazard_eval = 1'b1;
        end else begin
          stall_mem = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_d >= CNT_W'(MEM_TIMEOUT)) state_d = ERROR;
        end
      end
      ERROR: begin
        stall_mem = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    // The branch squashes the ID instruction, so it outranks a load-use hit on it.
    if (hazard_eval) begin
      if (ex_branch_taken_i) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (lu_hit) begin
        lu_stall = 1'b1;
        bubble   = 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is held, regardless of the data inputs.
  assign stall_if_o  = rst_ni && (stall_mem || lu_stall);
  assign stall_id_o  = rst_ni && stall_mem;
  assign stall_ex_o  = rst_ni && stall_mem;
  assign bubble_ex_o = rst_ni && bubble;
  assign flush_id_o  = rst_ni && flush;
  assign mem_err_o   = rst_ni && (state_q == ERROR);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (stall_if_o) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; output vector is {if,id,ex,bubble,flush,err}.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        id_uses_rs1_i, id_uses_rs2_i;
  logic        ex_mem_read_i, ex_branch_taken_i;
  logic        dmem_req_i, dmem_ready_i;
  logic        stall_if_o, stall_id_o, stall_ex_o;
  logic        bubble_ex_o, flush_id_o, mem_err_o;
  logic [31:0] stall_cycles_o;

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_uses_rs1_i     (id_uses_rs1_i),
    .id_uses_rs2_i     (id_uses_rs2_i),
    .ex_rd_i           (ex_rd_i),
    .ex_mem_read_i     (ex_mem_read_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .dmem_req_i        (dmem_req_i),
    .dmem_ready_i      (dmem_ready_i),
    .stall_if_o        (stall_if_o),
    .stall_id_o        (stall_id_o),
    .stall_ex_o        (stall_ex_o),
    .bubble_ex_o       (bubble_ex_o),
    .flush_id_o        (flush_id_o),
    .mem_err_o         (mem_err_o),
    .stall_cycles_o    (stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [5:0] outs();
    return {stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_id_o, mem_err_o};
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr, input logic br,
                        input logic req, input logic rdy);
    id_rs1_i = rs1; id_rs2_i = rs2; id_uses_rs1_i = u1; id_uses_rs2_i = u2;
    ex_rd_i = rd; ex_mem_read_i = mr; ex_branch_taken_i = br;
    dmem_req_i = req; dmem_ready_i = rdy;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_outs(input string name, input logic [5:0] exp);
    #1;
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", name, outs(), exp);
    end
  endtask

  task automatic pulse_reset();
    idle();
    @(negedge clk_i);
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    expect_outs("reset_outputs_low", 6'b000000);
    vectors++;
    if (stall_cycles_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counter: got %0d want 0", stall_cycles_o);
    end
    idle();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    expect_outs("idle_after_reset", 6'b000000);
  endtask

  task automatic test_load_use();
    step();
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_outs("load_use_rs1", 6'b100100);
    step();
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_outs("load_left_ex", 6'b000000);
    step();
    set_in(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_outs("load_use_rs2", 6'b100100);
    step();
  endtask

  task automatic test_no_hit();
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_outs("x0_no_hit", 6'b000000);
    step();
    set_in(5'd1, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_outs("unused_rs2_no_hit", 6'b000000);
    step();
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_outs("not_a_load_no_hit", 6'b000000);
    step();
  endtask

  task automatic test_branch();
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_outs("branch_beats_load_use", 6'b000110);
    step();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_outs("branch_alone", 6'b000110);
    step();
  endtask

  task automatic test_zero_wait();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_outs("zero_wait_access", 6'b000000);
    step();
    idle();
    expect_outs("zero_wait_stays_run", 6'b000000);
    step();
  endtask

  task automatic test_mem_wait();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_outs("mem_wait_c1", 6'b111000);
    step();
    ex_branch_taken_i = 1'b1;
    expect_outs("mem_wait_c2_branch_ignored", 6'b111000);
    step();
    ex_branch_taken_i = 1'b0;
    expect_outs("mem_wait_c3", 6'b111000);
    step();
    set_in(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_outs("ready_cycle_eval_load_use", 6'b100100);
    step();
    idle();
    expect_outs("back_in_run", 6'b000000);
    step();
  endtask

  task automatic test_timeout();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      expect_outs($sformatf("timeout_stall_c%0d", i + 1), 6'b111000);
      step();
    end
    expect_outs("error_entered", 6'b111001);
    step();
    dmem_ready_i = 1'b1;
    expect_outs("error_ignores_ready", 6'b111001);
    step();
    idle();
    expect_outs("error_sticky", 6'b111001);
    pulse_reset();
    expect_outs("error_cleared_by_reset", 6'b000000);
    step();
  endtask

  task automatic test_reset_mid_wait();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    expect_outs("in_mem_wait", 6'b111000);
    #1;
    rst_ni = 1'b0;
    expect_outs("async_reset_mid_wait", 6'b000000);
    dmem_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    expect_outs("run_after_abandoned_wait", 6'b000000);
  endtask

  task automatic test_perf_cnt();
    logic [31:0] exp_cnt;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_outs($sformatf("perf_stall_c%0d", i + 1), 6'b100100);
      step();
    end
    idle();
`ifdef HAZARD_PERF_CNT_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    #1;
    vectors++;
    if (stall_cycles_o !== exp_cnt) begin
      miscompares++;
      $display("FAIL stall_cycles: got %0d want %0d", stall_cycles_o, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hit();
    test_branch();
    test_zero_wait();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_perf_cnt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
